ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch unit on the consumer side of the program counter. Accepts a 32-bit fetch address via valid/ready, issues one read to instruction memory, waits for the response, and presents the instruction word plus its address to decode via valid/ready. Detects misaligned PCs, bus errors and response timeouts, and reports them as a fault code alongside the instruction.

## Interface
- TIMEOUT, 255: max cycles spent in WAIT without a response before a timeout fault; must be ≥1 and ≤ 2^CNT_W−1.
- CNT_W, 8: width of the internal timeout counter.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- pc_in  in  32  fetch address.
- pc_valid  in  1  pc_in valid.
- pc_ready  out  1  unit can accept an address.
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  32  request address.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  read data valid.
- mem_resp_data  in  32  read data.
- mem_resp_err  in  1  bus error, qualified by mem_resp_valid.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode consumes instruction.
- inst  out  32  instruction word.
- inst_pc  out  32  address the instruction was fetched from.
- fault  out  2  00 none, 01 misaligned, 10 bus error, 11 timeout.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, REQ, WAIT, OUT. Reset state: IDLE.
- Combinational decodes:
  - pc_ready = (state==IDLE) && !rst.
  - mem_req_valid = (state==REQ).
  - inst_valid = (state==OUT).
- IDLE: on pc_valid && pc_ready, latch pc_in into addr_q and inst_pc.
  - If pc_in[1:0] != 0: inst=0, fault=01, go to OUT. No memory request is issued.
  - Else: fault=00, go to REQ.
- REQ: mem_req_addr = addr_q, held stable until handshake. On mem_req_ready: clear counter, go to WAIT. No timeout in REQ.
- WAIT: on mem_resp_valid, go to OUT.
  - If mem_resp_err: inst=0, fault=10.
  - Else: inst=mem_resp_data, fault=00.
  - Without a response, the counter increments each cycle. On the cycle where counter == TIMEOUT−1 and no response arrives: inst=0, fault=11, go to OUT.
  - A response in that same cycle wins over the timeout.
- OUT: inst, inst_pc and fault are held stable until inst_ready; on handshake go to IDLE.
- mem_resp_valid outside WAIT (late or stray response) is ignored; no state change.
- mem_req_addr = addr_q in every state; only meaningful in REQ.
- One transaction in flight at most; no pipelining.

## Timing
- Reset values (state after any clk edge with rst=1): state IDLE, mem_req_valid 0, inst_valid 0, inst 0, inst_pc 0, fault 00, counter 0, busy 0.
- pc_ready is 0 while rst=1.
- Reset mid-transaction abandons the transaction. A response arriving after reset is dropped.
- Minimum latency, with mem_req_ready=1 and the response one cycle after the request:
  - cycle 0: pc handshake.
  - cycle 1: REQ, request accepted.
  - cycle 2: WAIT, response arrives.
  - cycle 3: inst_valid=1.
- Misaligned path: inst_valid=1 in the cycle after the pc handshake.
- Throughput: next pc handshake no earlier than the cycle after the inst handshake (IDLE). Minimum 4 cycles per fetch.
- Timeout fault: inst_valid rises exactly TIMEOUT cycles after entering WAIT.
- Valid outputs never drop without the matching ready, except on rst.

## Test plan
- Normal fetch: pc_in=0x8000_0000, memory ready=1, returns 0x0000_0413 one cycle later. Required: mem_req_addr=0x8000_0000; inst_valid at cycle 3 with inst=0x0000_0413, inst_pc=0x8000_0000, fault=00.
- Backpressure: mem_req_ready low 3 cycles, then high; inst_ready low 5 cycles. Required: mem_req_valid/addr stable throughout, inst/inst_pc stable throughout, exactly one request issued, one instruction delivered.
- Misaligned: pc_in=0x8000_0002. Required: no mem_req_valid ever; next cycle inst_valid=1, fault=01, inst=0, inst_pc=0x8000_0002.
- Bus error: response with mem_resp_err=1 and data 0xDEAD_BEEF. Required: fault=10, inst=0.
- Timeout, TIMEOUT=4, no response: inst_valid TIMEOUT cycles after WAIT entry with fault=11. A late response then arrives in IDLE. Required: ignored. A follow-up fetch of 0x8000_0004 completes normally.
- Reset mid-WAIT: rst for 1 cycle. Required: next cycle IDLE, all valids 0, fault 00. A subsequent stray mem_resp_valid produces no inst_valid.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: accepts a PC, issues one memory read, and hands the
// instruction word, its PC and a fault code to decode.
module ifu_fetch #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    input  logic        mem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [1:0]  fault,
    output logic        busy
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_BUS      = 2'b10;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   inst_q, inst_d;
    logic [1:0]          fault_q, fault_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; addr_q doubles as the reported inst_pc
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            inst_q  <= '0;
            fault_q <= FAULT_NONE;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pc_valid) begin
                    addr_d = pc_in;
                    if (pc_in[1:0] != 2'b00) begin
                        inst_d  = '0;
                        fault_d = FAULT_MISALIGN;
                        state_d = OUT;
                    end else begin
                        fault_d = FAULT_NONE;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A response in the final counted cycle beats the timeout
                if (mem_resp_valid) begin
                    inst_d  = mem_resp_err ? '0 : mem_resp_data;
                    fault_d = mem_resp_err ? FAULT_BUS : FAULT_NONE;
                    state_d = OUT;
                end else if (cnt_q == CNT_LAST) begin
                    inst_d  = '0;
                    fault_d = FAULT_TIMEOUT;
                    state_d = OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OUT: begin
                if (inst_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pc_ready      = (state_q == IDLE) && !rst;
    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = addr_q;
    assign inst_valid    = (state_q == OUT);
    assign inst          = inst_q;
    assign inst_pc       = addr_q;
    assign fault         = fault_q;
    assign busy          = (state_q != IDLE);

endmodule
